// File: rtl/decode_pkg.sv
// Shared parameters, types and helpers for the key decode block.
package decode_pkg;

  // Constant ceil(log2(v)) used for address and index widths.
  function automatic int unsigned CLOG2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned L1_LEN_MU  = 128;
  localparam int unsigned L1_B       = 2;
  localparam int unsigned L1_Q       = 32768;
  localparam int unsigned L1_WIDTH_Q = 15;
  localparam int unsigned L1_MBAR    = 8;
  localparam int unsigned L1_NBAR    = 8;

  localparam int unsigned L3_LEN_MU  = 192;
  localparam int unsigned L3_B       = 3;
  localparam int unsigned L3_Q       = 65536;
  localparam int unsigned L3_WIDTH_Q = 16;
  localparam int unsigned L3_MBAR    = 8;
  localparam int unsigned L3_NBAR    = 8;

  localparam int unsigned L5_LEN_MU  = 256;
  localparam int unsigned L5_B       = 4;
  localparam int unsigned L5_Q       = 65536;
  localparam int unsigned L5_WIDTH_Q = 16;
  localparam int unsigned L5_MBAR    = 8;
  localparam int unsigned L5_NBAR    = 8;

  localparam int unsigned T_ENCODE         = 4;
  localparam int unsigned WORD_SIZE_ENCODE = 64;

  localparam int unsigned ELEM_W     = 16;
  localparam int unsigned VAL_W      = 4;
  localparam int unsigned N_WORDS    = L5_MBAR * L5_NBAR / T_ENCODE;
  localparam int unsigned ADDR_W     = CLOG2(N_WORDS);
  localparam int unsigned N_GROUPS   = L5_LEN_MU / L5_B;
  localparam int unsigned ELEM_IDX_W = CLOG2(T_ENCODE);
  localparam int unsigned KPOS_W     = CLOG2(L5_LEN_MU);
  localparam int unsigned VIDX_W     = CLOG2(VAL_W);

  typedef enum logic [1:0] {
    LVL1 = 2'd0,
    LVL3 = 2'd1,
    LVL5 = 2'd2
  } level_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Unsupported level codes fall back to level 1.
  function automatic level_e to_level(input logic [2:0] sec);
    case (sec)
      3'd3:    return LVL3;
      3'd5:    return LVL5;
      default: return LVL1;
    endcase
  endfunction

  // Bits recovered per element at each level.
  function automatic int level_b(input level_e lvl);
    case (lvl)
      LVL3:    return int'(L3_B);
      LVL5:    return int'(L5_B);
      default: return int'(L1_B);
    endcase
  endfunction

endpackage

// File: rtl/decode_coeff.sv
// Rounds one 16-bit matrix element back to its B-bit key fragment.
module decode_coeff
  import decode_pkg::*;
(
  input  logic [ELEM_W-1:0] i_c,
  input  level_e            i_level,
  output logic [VAL_W-1:0]  o_v_c
);

  localparam int unsigned RND_L1 = 1 << (L1_WIDTH_Q - L1_B - 1);
  localparam int unsigned RND_L3 = 1 << (L3_WIDTH_Q - L3_B - 1);
  localparam int unsigned RND_L5 = 1 << (L5_WIDTH_Q - L5_B - 1);

  logic [L1_WIDTH_Q-1:0] w_sum_l1;
  logic [L3_WIDTH_Q-1:0] w_sum_l3;
  logic [L5_WIDTH_Q-1:0] w_sum_l5;

  // Rounding sums wrap at the element width of each level.
  assign w_sum_l1 = i_c[L1_WIDTH_Q-1:0] + L1_WIDTH_Q'(RND_L1);
  assign w_sum_l3 = i_c[L3_WIDTH_Q-1:0] + L3_WIDTH_Q'(RND_L3);
  assign w_sum_l5 = i_c[L5_WIDTH_Q-1:0] + L5_WIDTH_Q'(RND_L5);

  // Keep the top B bits of the rounded element.
  always_comb begin
    o_v_c = '0;
    case (i_level)
      LVL3:    o_v_c = {1'b0, w_sum_l3[L3_WIDTH_Q-1 -: L3_B]};
      LVL5:    o_v_c = w_sum_l5[L5_WIDTH_Q-1 -: L5_B];
      default: o_v_c = {2'b00, w_sum_l1[L1_WIDTH_Q-1 -: L1_B]};
    endcase
  end

endmodule

// File: rtl/decode.sv
// Key decode: streams the k_mat words, rounds each element and rebuilds the key.
// Optional macro DECODE_PIPE_EN adds a register stage on i_k_mat before rounding.
module decode
  import decode_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [2:0]                  i_sec_level,
  output logic                        o_k_mat_ren,
  output logic [ADDR_W-1:0]           o_k_mat_addr,
  input  logic [WORD_SIZE_ENCODE-1:0] i_k_mat,
  output logic [L5_LEN_MU-1:0]        o_k,
  output logic                        o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_e                        r_state;
  state_e                        w_next;
  level_e                        r_level;
  logic [ADDR_W-1:0]             r_addr;
  logic [ADDR_W-1:0]             w_addr_next;
  logic                          r_ren;
  logic                          r_done;
  logic [L5_LEN_MU-1:0]          r_k;
  logic [L5_LEN_MU-1:0]          w_k_upd;
  logic                          r_rd_vld;
  logic [ADDR_W-1:0]             r_rd_idx;
  logic                          w_cap_vld;
  logic [ADDR_W-1:0]             w_cap_idx;
  logic [WORD_SIZE_ENCODE-1:0]   w_cap_data;
  logic [T_ENCODE-1:0][VAL_W-1:0] w_v;
  int                            w_g;
  int                            w_b;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and next address; a start restarts from any state.
  always_comb begin
    w_next      = r_state;
    w_addr_next = r_addr;
    case (r_state)
      S_READ: begin
        if (r_addr == LAST_ADDR) w_next = S_DRAIN;
        else                     w_addr_next = r_addr + ADDR_W'(1);
      end
      S_DRAIN: begin
        if (w_cap_vld && (w_cap_idx == LAST_ADDR)) w_next = S_DONE;
      end
      default: ;
    endcase
    if (i_start) begin
      w_next      = S_READ;
      w_addr_next = '0;
    end
  end

  // Registered outputs and level latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_ren   <= 1'b0;
      r_done  <= 1'b0;
      r_level <= LVL1;
    end else begin
      r_addr <= w_addr_next;
      r_ren  <= (w_next == S_READ);
      r_done <= (w_next == S_DONE);
      if (i_start) r_level <= to_level(i_sec_level);
    end
  end

  // Track which word the memory returns next cycle; a restart drops in-flight reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_idx <= '0;
    end else begin
      r_rd_vld <= r_ren && !i_start;
      r_rd_idx <= r_addr;
    end
  end

`ifdef DECODE_PIPE_EN
  logic                        r_pipe_vld;
  logic [ADDR_W-1:0]           r_pipe_idx;
  logic [WORD_SIZE_ENCODE-1:0] r_pipe_data;

  // Extra register stage on the read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_vld  <= 1'b0;
      r_pipe_idx  <= '0;
      r_pipe_data <= '0;
    end else begin
      r_pipe_vld  <= r_rd_vld && !i_start;
      r_pipe_idx  <= r_rd_idx;
      r_pipe_data <= i_k_mat;
    end
  end

  assign w_cap_vld  = r_pipe_vld;
  assign w_cap_idx  = r_pipe_idx;
  assign w_cap_data = r_pipe_data;
`else
  assign w_cap_vld  = r_rd_vld;
  assign w_cap_idx  = r_rd_idx;
  assign w_cap_data = i_k_mat;
`endif

  // One rounding unit per element of a word.
  for (genvar r = 0; r < T_ENCODE; r++) begin : g_coeff
    decode_coeff u_coeff (
      .i_c     (w_cap_data[r*ELEM_W +: ELEM_W]),
      .i_level (r_level),
      .o_v_c   (w_v[r])
    );
  end

  // Scatter the word's fragments into key bit positions (bit order reversed within bytes).
  always_comb begin
    w_k_upd = r_k;
    w_b     = level_b(r_level);
    w_g     = 0;
    for (int r = 0; r < int'(T_ENCODE); r++) begin
      w_g = int'(N_GROUPS) - 1 - (int'(w_cap_idx) * int'(T_ENCODE) + int'(T_ENCODE) - 1 - r);
      for (int b = 0; b < int'(VAL_W); b++) begin
        if (b < w_b) begin
          w_k_upd[KPOS_W'((w_g * w_b + b) ^ 7)] = w_v[ELEM_IDX_W'(r)][VIDX_W'(w_b - 1 - b)];
        end
      end
    end
  end

  // Key accumulator; cleared on start so an aborted run leaves nothing behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_k <= '0;
    else if (i_start)   r_k <= '0;
    else if (w_cap_vld) r_k <= w_k_upd;
  end

  assign o_k_mat_ren  = r_ren;
  assign o_k_mat_addr = r_addr;
  assign o_k          = r_k;
  assign o_done       = r_done;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode; memory filled by an encode model.
module tb_decode;
  import decode_pkg::*;

`ifdef DECODE_PIPE_EN
  localparam int DONE_CYC = 19;
`else
  localparam int DONE_CYC = 18;
`endif

  logic                        clk;
  logic                        rst_n;
  logic                        start;
  logic [2:0]                  sec_level;
  logic                        ren;
  logic [ADDR_W-1:0]           addr;
  logic [WORD_SIZE_ENCODE-1:0] k_mat;
  logic [L5_LEN_MU-1:0]        k;
  logic                        done;

  logic [WORD_SIZE_ENCODE-1:0] mem [N_WORDS];

  int n_checks = 0;
  int n_errors = 0;

  decode dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_sec_level  (sec_level),
    .o_k_mat_ren  (ren),
    .o_k_mat_addr (addr),
    .i_k_mat      (k_mat),
    .o_k          (k),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, data one cycle after ren.
  always @(posedge clk) begin
    if (ren) k_mat <= mem[addr];
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] lvl_mask(input int lvl);
    logic [255:0] m;
    int len;
    len = (lvl == 3) ? 192 : (lvl == 5) ? 256 : 128;
    m = '0;
    for (int i = 0; i < len; i++) m[8'(i)] = 1'b1;
    return m;
  endfunction

  // Encode model: fragment v shifted to the top B bits of a D-bit element.
  function automatic logic [63:0] enc_word(input logic [255:0] key, input int lvl, input int w);
    logic [63:0] word;
    logic [15:0] e;
    logic [3:0]  v;
    int bb, dd, g;
    bb = (lvl == 3) ? 3 : (lvl == 5) ? 4 : 2;
    dd = (lvl == 3 || lvl == 5) ? 16 : 15;
    word = '0;
    for (int r = 0; r < 4; r++) begin
      g = 63 - (4 * w + 3 - r);
      v = '0;
      for (int b = 0; b < bb; b++) v[2'(bb - 1 - b)] = key[8'((g * bb + b) ^ 7)];
      e = 16'(v) << (dd - bb);
      word[6'(16 * r) +: 16] = e;
    end
    return word;
  endfunction

  task automatic load_key(input logic [255:0] key, input int lvl);
    for (int w = 0; w < int'(N_WORDS); w++) mem[w] = enc_word(key, lvl, w);
  endtask

  task automatic load_elem0(input logic [15:0] e);
    for (int w = 0; w < int'(N_WORDS); w++) mem[w] = '0;
    mem[0][15:0] = e;
  endtask

  // Pulse start for one edge; returns at the falling edge of cycle 1.
  task automatic start_pulse(input int lvl);
    sec_level = 3'(lvl);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(done), 256'd1);
  endtask

  task automatic run_key(input string tag, input logic [255:0] key, input int lvl);
    load_key(key, lvl);
    start_pulse(lvl);
    wait_done({tag, "_done"});
    check(tag, k, key & lvl_mask(lvl));
  endtask

  task automatic run_elem(input string tag, input logic [15:0] e, input int lvl,
                          input logic [255:0] exp);
    load_elem0(e);
    start_pulse(lvl);
    wait_done({tag, "_done"});
    check(tag, k, exp);
  endtask

  logic [255:0] key_a, key_b, rk;
  logic [255:0] pat;
  int seen_done;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sec_level = 3'd0;
    for (int w = 0; w < int'(N_WORDS); w++) mem[w] = '0;
    repeat (2) @(negedge clk);
    check("rst_ren", 256'(ren), 256'd0);
    check("rst_addr", 256'(addr), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_k", k, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle-accurate read sequence and done latency.
    load_key({64{4'hA}}, 5);
    start_pulse(5);
    for (int a = 0; a < 16; a++) begin
      check($sformatf("tim_ren_c%0d", a + 1), 256'(ren), 256'd1);
      check($sformatf("tim_addr_c%0d", a + 1), 256'(addr), 256'(a));
      @(negedge clk);
    end
    for (int c = 17; c <= DONE_CYC; c++) begin
      check($sformatf("tim_ren_c%0d", c), 256'(ren), 256'd0);
      check($sformatf("tim_done_c%0d", c), 256'(done), (c == DONE_CYC) ? 256'd1 : 256'd0);
      if (c != DONE_CYC) @(negedge clk);
    end
    check("tim_key", k, {64{4'hA}});
    repeat (3) @(negedge clk);
    check("hold_done", 256'(done), 256'd1);
    check("hold_key", k, {64{4'hA}});

    // Rounding boundaries on element 0 of word 0.
    run_elem("l5_0800", 16'h0800, 5, 256'd1 << 244);
    run_elem("l5_07ff", 16'h07FF, 5, 256'd0);
    run_elem("l5_f800", 16'hF800, 5, 256'd0);
    run_elem("l5_f7ff", 16'hF7FF, 5, 256'hF << 244);
    run_elem("l1_7000", 16'h7000, 1, 256'd0);
    run_elem("l1_6fff", 16'h6FFF, 1, 256'h3 << 126);
    run_elem("l1_f000", 16'hF000, 1, 256'd0);
    run_elem("l3_1000", 16'h1000, 3, 256'd1 << 177);

    // Directed round trips.
    pat = {4{64'h0123456789ABCDEF}};
    for (int li = 0; li < 3; li++) begin
      int lvl;
      lvl = (li == 0) ? 1 : (li == 1) ? 3 : 5;
      run_key($sformatf("rt_zero_l%0d", lvl), '0, lvl);
      run_key($sformatf("rt_ones_l%0d", lvl), '1, lvl);
      run_key($sformatf("rt_pat_l%0d", lvl), pat, lvl);
    end

    // Random round trips.
    for (int li = 0; li < 3; li++) begin
      int lvl;
      lvl = (li == 0) ? 1 : (li == 1) ? 3 : 5;
      for (int i = 0; i < 100; i++) begin
        for (int j = 0; j < 8; j++) rk[8'(32 * j) +: 32] = $urandom;
        run_key($sformatf("rt_rnd_l%0d_%0d", lvl, i), rk, lvl);
      end
    end

    // Restart at cycle 7 with a different key.
    key_a = {8{32'hDEADBEEF}};
    key_b = {8{32'h13579BDF}};
    load_key(key_a, 3);
    start_pulse(3);
    repeat (6) @(negedge clk);
    load_key(key_b, 3);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rs_addr_c8", 256'(addr), 256'd0);
    check("rs_ren_c8", 256'(ren), 256'd1);
    for (int c = 8; c < DONE_CYC + 6; c++) @(negedge clk);
    check("rs_done_early", 256'(done), 256'd0);
    @(negedge clk);
    check("rs_done", 256'(done), 256'd1);
    check("rs_key", k, key_b & lvl_mask(3));

    // Asynchronous reset mid-run.
    load_key('1, 5);
    start_pulse(5);
    repeat (8) @(negedge clk);
    check("pre_rst_k_nz", 256'(k != '0), 256'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ren", 256'(ren), 256'd0);
    check("mid_rst_done", 256'(done), 256'd0);
    check("mid_rst_k", k, 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("post_rst_no_done", 256'(seen_done), 256'd0);

    // Level 6 behaves as level 1.
    pat = {4{64'hF0E1D2C3B4A59687}};
    load_key(pat, 1);
    start_pulse(6);
    wait_done("lvl6_done");
    check("lvl6_key", k, pat & lvl_mask(1));

    // Level change mid-run is ignored.
    load_key(pat, 5);
    start_pulse(5);
    repeat (2) @(negedge clk);
    sec_level = 3'd1;
    wait_done("lvlchg_done");
    check("lvlchg_key", k, pat);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
